// File: rtl/t00_flex_counter_pkg.sv
// Shared types and defaults for the t00 up/down flex counter.
// Optional prescaler is enabled with macro T00_FLEX_COUNTER_PRESCALE_EN.
package t00_flex_counter_pkg;

  typedef enum logic {DIR_UP, DIR_DOWN} count_dir_e;

  localparam int unsigned DEFAULT_NUM_BITS      = 4;
  localparam int unsigned DEFAULT_PRESCALE_BITS = 4;

endpackage

// File: rtl/t00_flex_prescaler.sv
// Tick counter that strobes o_step on every (i_prescale_val+1)th enabled cycle.
// Used by t00_flex_counter_ud only when T00_FLEX_COUNTER_PRESCALE_EN is defined.
module t00_flex_prescaler
  import t00_flex_counter_pkg::*;
#(
  parameter int unsigned PRESCALE_BITS = DEFAULT_PRESCALE_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_enable,
  input  logic [PRESCALE_BITS-1:0] i_prescale_val,
  output logic                     o_step
);

  logic [PRESCALE_BITS-1:0] r_tick;
  logic                     w_hit;

  // >= rather than == so a prescale value lowered mid-count cannot strand the tick.
  assign w_hit  = (r_tick >= i_prescale_val);
  assign o_step = i_enable & w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= '0;
    end else if (i_clear) begin
      r_tick <= '0;
    end else if (i_enable) begin
      r_tick <= w_hit ? '0 : r_tick + 1'b1;
    end
  end

endmodule

// File: rtl/t00_flex_counter_ud.sv
// Up/down flex counter: programmable terminal, parallel load, wrap or one-shot.
// Define T00_FLEX_COUNTER_PRESCALE_EN to add the prescale_val input and tick prescaler.
module t00_flex_counter_ud
  import t00_flex_counter_pkg::*;
#(
  parameter int unsigned NUM_BITS      = DEFAULT_NUM_BITS,
  parameter int unsigned PRESCALE_BITS = DEFAULT_PRESCALE_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load_en,
  input  logic [NUM_BITS-1:0] load_val,
  input  logic                count_enable,
  input  logic                dir,
  input  logic                one_shot,
  input  logic [NUM_BITS-1:0] rollover_val,
`ifdef T00_FLEX_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_BITS-1:0] prescale_val,
`endif
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag,
  output logic                wrap_pulse,
  output logic                done
);

  localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

  logic [NUM_BITS-1:0] r_count, w_count_nxt;
  logic                r_flag, w_flag_nxt;
  logic                r_wrap, w_wrap_nxt;
  logic                r_done, w_done_nxt;
  logic                w_step;
  logic [NUM_BITS-1:0] w_term;
  logic                w_rv_zero;
  logic                w_at_term;
  count_dir_e          w_dir;

`ifdef T00_FLEX_COUNTER_PRESCALE_EN
  t00_flex_prescaler #(
    .PRESCALE_BITS (PRESCALE_BITS)
  ) u_prescaler (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (clear | load_en),
    .i_enable       (count_enable),
    .i_prescale_val (prescale_val),
    .o_step         (w_step)
  );
`else
  logic [PRESCALE_BITS-1:0] w_unused_prescale;
  assign w_unused_prescale = '0;
  assign w_step            = count_enable;
`endif

  assign w_dir     = count_dir_e'(dir);
  assign w_term    = (w_dir == DIR_DOWN) ? ONE : rollover_val;
  assign w_rv_zero = (rollover_val == '0);
  assign w_at_term = !w_rv_zero && (r_count == w_term);

  always_comb begin
    w_count_nxt = r_count;
    w_flag_nxt  = r_flag;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = r_done;
    if (clear) begin
      w_count_nxt = '0;
      w_done_nxt  = 1'b0;
      w_flag_nxt  = !w_rv_zero && (w_term == '0);
    end else if (load_en) begin
      w_count_nxt = load_val;
      w_done_nxt  = 1'b0;
      w_flag_nxt  = !w_rv_zero && (load_val == w_term);
    end else if (w_step && !r_done) begin
      if (w_rv_zero) begin
        w_flag_nxt = 1'b0;
      end else if (one_shot && w_at_term) begin
        // Reached terminal in one-shot mode without a step landing on it (e.g. loaded there).
        w_done_nxt = 1'b1;
        w_flag_nxt = 1'b1;
      end else begin
        if (w_dir == DIR_UP) begin
          w_count_nxt = (r_count >= rollover_val) ? ONE : r_count + 1'b1;
        end else if (r_count <= ONE || r_count > rollover_val) begin
          w_count_nxt = rollover_val;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
        w_wrap_nxt = w_at_term && !one_shot;
        w_flag_nxt = (w_count_nxt == w_term);
        w_done_nxt = one_shot && (w_count_nxt == w_term);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_flag  <= w_flag_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_flag;
  assign wrap_pulse    = r_wrap;
  assign done          = r_done;

endmodule

// File: tb/tb_t00_flex_counter_ud.sv
// Directed self-checking bench for t00_flex_counter_ud (NUM_BITS=4).
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_t00_flex_counter_ud;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       load_en;
  logic [3:0] load_val;
  logic       count_enable;
  logic       dir;
  logic       one_shot;
  logic [3:0] rollover_val;
  logic [3:0] prescale_val;
  logic [3:0] count_out;
  logic       rollover_flag;
  logic       wrap_pulse;
  logic       done;

  int checks;
  int errors;

  t00_flex_counter_ud #(
    .NUM_BITS      (4),
    .PRESCALE_BITS (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .load_en       (load_en),
    .load_val      (load_val),
    .count_enable  (count_enable),
    .dir           (dir),
    .one_shot      (one_shot),
    .rollover_val  (rollover_val),
`ifdef T00_FLEX_COUNTER_PRESCALE_EN
    .prescale_val  (prescale_val),
`endif
    .count_out     (count_out),
    .rollover_flag (rollover_flag),
    .wrap_pulse    (wrap_pulse),
    .done          (done)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 0; load_en = 0; load_val = 0; count_enable = 0;
    dir = 0; one_shot = 0; rollover_val = 4'd11; prescale_val = 0;
    tick(2);
    checks++;
    if ({count_out, rollover_flag, wrap_pulse, done} !== 7'd0) begin
      errors++; $display("FAIL reset_initial: got %0d/%b/%b/%b want 0/0/0/0", count_out, rollover_flag, wrap_pulse, done);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    count_enable = 1'b1;
    tick(5);
    checks++;
    if (count_out !== 4'd5) begin
      errors++; $display("FAIL reset_precount: got %0d want 5", count_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({count_out, rollover_flag, wrap_pulse, done} !== 7'd0) begin
      errors++; $display("FAIL reset_async: got %0d/%b/%b/%b want 0/0/0/0", count_out, rollover_flag, wrap_pulse, done);
    end
    tick(1);
    checks++;
    if (count_out !== 4'd0) begin
      errors++; $display("FAIL reset_hold_edge: got %0d want 0", count_out);
    end
    count_enable = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if ({count_out, rollover_flag, wrap_pulse, done} !== 7'd0) begin
      errors++; $display("FAIL reset_release: got %0d/%b/%b/%b want 0/0/0/0", count_out, rollover_flag, wrap_pulse, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_up_wrap();
    rollover_val = 4'd11; dir = 0; one_shot = 0; count_enable = 1;
    tick(11);
    checks++;
    if (count_out !== 4'd11 || rollover_flag !== 1'b1 || wrap_pulse !== 1'b0) begin
      errors++; $display("FAIL up_at_term: got %0d/%b/%b want 11/1/0", count_out, rollover_flag, wrap_pulse);
    end
    tick(1);
    checks++;
    if (count_out !== 4'd1 || rollover_flag !== 1'b0 || wrap_pulse !== 1'b1) begin
      errors++; $display("FAIL up_wrap: got %0d/%b/%b want 1/0/1", count_out, rollover_flag, wrap_pulse);
    end
    tick(1);
    checks++;
    if (count_out !== 4'd2 || wrap_pulse !== 1'b0) begin
      errors++; $display("FAIL up_wrap_drop: got %0d/%b want 2/0", count_out, wrap_pulse);
    end
    count_enable = 0;
    tick(2);
    checks++;
    if (count_out !== 4'd2 || rollover_flag !== 1'b0) begin
      errors++; $display("FAIL up_hold: got %0d/%b want 2/0", count_out, rollover_flag);
    end
  endtask

  task automatic test_down_load();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'd4, 4'd3, 4'd2, 4'd1};
    load_en = 1; load_val = 4'd5; dir = 1; rollover_val = 4'd9;
    tick(1);
    checks++;
    if (count_out !== 4'd5 || rollover_flag !== 1'b0) begin
      errors++; $display("FAIL down_load: got %0d/%b want 5/0", count_out, rollover_flag);
    end
    load_en = 0; count_enable = 1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if (count_out !== exp_seq[i] || rollover_flag !== (i == 3)) begin
        errors++; $display("FAIL down_step%0d: got %0d/%b want %0d/%b", i, count_out, rollover_flag, exp_seq[i], (i == 3));
      end
    end
    tick(1);
    checks++;
    if (count_out !== 4'd9 || wrap_pulse !== 1'b1 || rollover_flag !== 1'b0) begin
      errors++; $display("FAIL down_wrap: got %0d/%b/%b want 9/1/0", count_out, wrap_pulse, rollover_flag);
    end
    count_enable = 0;
    tick(1);
    checks++;
    if (wrap_pulse !== 1'b0 || count_out !== 4'd9) begin
      errors++; $display("FAIL down_wrap_drop: got %0d/%b want 9/0", count_out, wrap_pulse);
    end
  endtask

  task automatic test_one_shot();
    clear = 1;
    tick(1);
    clear = 0; rollover_val = 4'd6; one_shot = 1; dir = 0; count_enable = 1;
    tick(6);
    checks++;
    if (count_out !== 4'd6 || done !== 1'b1 || rollover_flag !== 1'b1) begin
      errors++; $display("FAIL oneshot_stop: got %0d/%b/%b want 6/1/1", count_out, done, rollover_flag);
    end
    tick(5);
    checks++;
    if (count_out !== 4'd6 || done !== 1'b1 || wrap_pulse !== 1'b0) begin
      errors++; $display("FAIL oneshot_held: got %0d/%b/%b want 6/1/0", count_out, done, wrap_pulse);
    end
    count_enable = 0; clear = 1;
    tick(1);
    checks++;
    if (count_out !== 4'd0 || done !== 1'b0 || rollover_flag !== 1'b0) begin
      errors++; $display("FAIL oneshot_clear: got %0d/%b/%b want 0/0/0", count_out, done, rollover_flag);
    end
    clear = 0; one_shot = 0;
  endtask

  task automatic test_priority();
    clear = 1; load_en = 1; load_val = 4'd7; count_enable = 1; rollover_val = 4'd9; dir = 0;
    tick(1);
    checks++;
    if (count_out !== 4'd0) begin
      errors++; $display("FAIL prio_clear_load: got %0d want 0", count_out);
    end
    clear = 0;
    tick(1);
    checks++;
    if (count_out !== 4'd7) begin
      errors++; $display("FAIL prio_load_enable: got %0d want 7", count_out);
    end
    load_en = 0; count_enable = 0;
    tick(1);
  endtask

  task automatic test_boundaries();
    rollover_val = 4'd9; dir = 1; load_en = 1; load_val = 4'd12;
    tick(1);
    load_en = 0; count_enable = 1;
    tick(1);
    checks++;
    if (count_out !== 4'd9 || wrap_pulse !== 1'b0 || rollover_flag !== 1'b0) begin
      errors++; $display("FAIL down_above_rv: got %0d/%b/%b want 9/0/0", count_out, wrap_pulse, rollover_flag);
    end
    count_enable = 0; dir = 0; load_en = 1; load_val = 4'd12;
    tick(1);
    load_en = 0; count_enable = 1;
    tick(1);
    checks++;
    if (count_out !== 4'd1 || wrap_pulse !== 1'b0 || rollover_flag !== 1'b0) begin
      errors++; $display("FAIL up_above_rv: got %0d/%b/%b want 1/0/0", count_out, wrap_pulse, rollover_flag);
    end
    count_enable = 0; dir = 1; rollover_val = 4'd5; load_en = 1; load_val = 4'd1;
    tick(1);
    checks++;
    if (count_out !== 4'd1 || rollover_flag !== 1'b1) begin
      errors++; $display("FAIL load_at_term: got %0d/%b want 1/1", count_out, rollover_flag);
    end
    load_val = 4'd3; rollover_val = 4'd0;
    tick(1);
    load_en = 0; count_enable = 1;
    tick(3);
    checks++;
    if (count_out !== 4'd3 || rollover_flag !== 1'b0 || wrap_pulse !== 1'b0) begin
      errors++; $display("FAIL rv_zero_hold: got %0d/%b/%b want 3/0/0", count_out, rollover_flag, wrap_pulse);
    end
    count_enable = 0;
  endtask

`ifdef T00_FLEX_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    clear = 1;
    tick(1);
    clear = 0; prescale_val = 4'd2; rollover_val = 4'd13; dir = 0; count_enable = 1;
    tick(9);
    checks++;
    if (count_out !== 4'd3) begin
      errors++; $display("FAIL prescale_count: got %0d want 3", count_out);
    end
    count_enable = 0;
    tick(5);
    checks++;
    if (count_out !== 4'd3) begin
      errors++; $display("FAIL prescale_hold: got %0d want 3", count_out);
    end
    prescale_val = 0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_up_wrap();
    test_down_load();
    test_one_shot();
    test_priority();
    test_boundaries();
`ifdef T00_FLEX_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t00_flex_counter_ud.md
Name: t00_flex_counter_ud

Overview:
Parametrised up/down flexible counter with programmable terminal value, parallel load, wrap or one-shot mode, and registered status outputs. It is the next-generation flex counter for timing, beat and sample-index generation in team_00 datapaths. It replaces fixed up-only counting where direction, preload or stop-at-terminal behaviour is needed.

Parameters:
- NUM_BITS, 4, width of count, rollover_val and load_val.
- PRESCALE_BITS, 4, width of prescale_val; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- clear  input  1  synchronous clear to 0.
- load_en  input  1  synchronous parallel load.
- load_val  input  NUM_BITS  value loaded when load_en=1.
- count_enable  input  1  advance the counter one step.
- dir  input  1  0 = up, 1 = down.
- one_shot  input  1  0 = wrap at terminal, 1 = stop at terminal.
- rollover_val  input  NUM_BITS  terminal/reload value.
- count_out  output  NUM_BITS  registered count.
- rollover_flag  output  1  registered; high while count_out is at the current terminal value.
- wrap_pulse  output  1  registered single-cycle pulse on a wrap.
- done  output  1  registered; high while one-shot has stopped.

Behaviour:
- Reset (rst=1, asynchronous): count_out=0, rollover_flag=0, wrap_pulse=0, done=0. Outputs hold these values while rst is high, regardless of clk.
- Priority per rising edge: rst > clear > load_en > count_enable > hold.
- clear: count_out=0, done=0, wrap_pulse=0. The flag is recomputed from 0.
- load_en: count_out=load_val, done=0, wrap_pulse=0. The flag is recomputed from load_val.
- Terminal value T: rollover_val when dir=0; 1 when dir=1.
- Up step (dir=0):
  - count >= rollover_val (and rollover_val != 0) -> next count 1.
  - Otherwise next count = count+1.
- Down step (dir=1):
  - count == 1 or count == 0 -> next count rollover_val.
  - count > rollover_val -> next count rollover_val.
  - Otherwise next count = count-1.
- Degenerate case: rollover_val=0 -> counter holds and rollover_flag=0 in both directions.
- Wrap: a step taken while count_out==T with one_shot=0. The following cycle has wrap_pulse=1, which lasts exactly one cycle.
- One-shot (one_shot=1): when count_out reaches T, done=1 is set in the same cycle as rollover_flag. Further count_enable is ignored, with count held and no wrap_pulse, until clear or load_en.
- rollover_flag timing: updated from the next-state count, so it is aligned with count_out with zero extra latency. It is held unchanged while count_enable=0.
- dir, one_shot and rollover_val may change on any cycle. The new value takes effect on the next step, using the comparisons above; there is no glitch or multi-step jump.
- count_enable=0: all state is held and wrap_pulse drops to 0.

Optional Feature:
- Macro T00_FLEX_COUNTER_PRESCALE_EN.
- When defined:
  - Adds input prescale_val[PRESCALE_BITS-1:0] and an internal tick counter.
  - The count steps only on every (prescale_val+1)th cycle with count_enable=1.
  - The tick counter clears on rst, clear and load_en, holds while count_enable=0, and restarts at 0 after each step.
  - prescale_val=0 is identical to the undefined behaviour.
- When undefined: there is no prescale_val port and every enabled cycle is a step.

Decomposition:
- Package t00_flex_counter_pkg holds:
  - typedef enum logic {DIR_UP, DIR_DOWN} count_dir_e;
  - localparams DEFAULT_NUM_BITS and DEFAULT_PRESCALE_BITS.
- Sub-module t00_flex_prescaler is the tick counter producing a step strobe. It is instantiated only under T00_FLEX_COUNTER_PRESCALE_EN.

Test Plan:
- Reset check: assert rst mid-count at count 5 -> outputs go to 0 without a clock edge and stay 0 across a clock edge. Release at negedge -> outputs still 0.
- Up wrap: NUM_BITS=4, rollover_val=11, dir=0, enable held for 11 cycles -> count_out=11 with rollover_flag=1. Next cycle -> count_out=1, rollover_flag=0, wrap_pulse=1. One cycle later -> wrap_pulse=0.
- Down with load: load_val=5 loaded, dir=1, rollover_val=9, enable held -> sequence 4,3,2,1 with the flag at 1. Next step -> 9 with wrap_pulse=1.
- One-shot: rollover_val=6, one_shot=1, up from 0 -> stops at 6 with done=1 and rollover_flag=1. Five more enabled cycles -> still 6. Then clear -> count 0, done=0.
- Priority: clear=1 and load_en=1 with load_val=7 in the same cycle -> count 0. Then load_en alone with count_enable=1 -> count 7, not 8.
- Prescale (macro defined): prescale_val=2, rollover_val=13, enable held for 9 cycles -> count_out=3. Deassert enable for 5 cycles -> count_out=3 held.
